// File: rtl/game_board_pkg.sv
// Shared types and codes for the tic-tac-toe board.
// Cells are 2-bit marks packed row-major into an 18-bit board.
package game_board_pkg;

  typedef logic [3:0] INDEX_T;
  typedef logic [1:0] STATE_T;
  typedef logic       FLAG_T;

  localparam STATE_T CELL_EMPTY = 2'd0;
  localparam STATE_T CELL_X     = 2'd1;
  localparam STATE_T CELL_O     = 2'd2;

  localparam logic [1:0] GAME_PLAY = 2'd0;
  localparam logic [1:0] GAME_XWIN = 2'd1;
  localparam logic [1:0] GAME_OWIN = 2'd2;
  localparam logic [1:0] GAME_DRAW = 2'd3;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OVER     = 3'd1;
  localparam logic [2:0] ERR_RANGE    = 3'd2;
  localparam logic [2:0] ERR_VALUE    = 3'd3;
  localparam logic [2:0] ERR_OCCUPIED = 3'd4;
  localparam logic [2:0] ERR_TURN     = 3'd5;

  function automatic STATE_T cell_at(
    input logic [17:0] b,
    input int          i
  );
    return b[2*i +: 2];
  endfunction

endpackage

// File: rtl/game_board_line_check.sv
// Combinational three-in-a-row detector.
// Reports, per player, whether any of the 8 lines is fully owned.
module line_check_m
  import game_board_pkg::*;
(
  input  logic [17:0] board,
  output logic        x_win,
  output logic        o_win
);

  function automatic logic line(
    input logic [17:0] b,
    input STATE_T      p,
    input int          a,
    input int          c,
    input int          d
  );
    return (cell_at(b, a) == p) &&
           (cell_at(b, c) == p) &&
           (cell_at(b, d) == p);
  endfunction

  function automatic logic any_line(
    input logic [17:0] b,
    input STATE_T      p
  );
    return line(b, p, 0, 1, 2) |
           line(b, p, 3, 4, 5) |
           line(b, p, 6, 7, 8) |
           line(b, p, 0, 3, 6) |
           line(b, p, 1, 4, 7) |
           line(b, p, 2, 5, 8) |
           line(b, p, 0, 4, 8) |
           line(b, p, 2, 4, 6);
  endfunction

  assign x_win = any_line(board, CELL_X);
  assign o_win = any_line(board, CELL_O);

endmodule

// File: rtl/game_board_m.sv
// Registered tic-tac-toe board: move legality, commit, turn,
// move count, win/draw status and rejected-move error pulse.
module game_board_m
  import game_board_pkg::*;
#(
  parameter STATE_T FIRST_PLAYER = CELL_X
) (
  input  logic        clk,
  input  FLAG_T       reset,
  input  logic        update_valid,
  input  INDEX_T      update_loc,
  input  STATE_T      update_val,
  output logic [17:0] board,
  output STATE_T      turn,
  output logic [3:0]  move_count,
  output logic [1:0]  game_state,
  output logic        err,
  output logic [2:0]  err_code
);

  logic        occupied;
  logic [2:0]  code;
  logic        legal;
  logic [17:0] next_board;
  logic [3:0]  next_count;
  logic        x_win;
  logic        o_win;

  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (update_loc == INDEX_T'(i))
        occupied = cell_at(board, i) != CELL_EMPTY;
    end
  end

  // First failing check wins, in priority order.
  always_comb begin
    code = ERR_NONE;
    if (game_state != GAME_PLAY)
      code = ERR_OVER;
    else if (update_loc > 4'd8)
      code = ERR_RANGE;
    else if (update_val != CELL_X && update_val != CELL_O)
      code = ERR_VALUE;
    else if (occupied)
      code = ERR_OCCUPIED;
    else if (update_val != turn)
      code = ERR_TURN;
  end

  assign legal      = update_valid && (code == ERR_NONE);
  assign next_count = move_count + 4'd1;

  always_comb begin
    next_board = board;
    for (int i = 0; i < 9; i++) begin
      if (legal && update_loc == INDEX_T'(i))
        next_board[2*i +: 2] = update_val;
    end
  end

  line_check_m u_line_check (
    .board (next_board),
    .x_win (x_win),
    .o_win (o_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      board      <= '0;
      turn       <= FIRST_PLAYER;
      move_count <= 4'd0;
      game_state <= GAME_PLAY;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      err <= 1'b0;
      if (update_valid) begin
        err      <= code != ERR_NONE;
        err_code <= code;
      end
      if (legal) begin
        board      <= next_board;
        turn       <= (turn == CELL_X) ? CELL_O : CELL_X;
        move_count <= next_count;
        // Board was win-free before, so any line now is the mover's.
        if (x_win)
          game_state <= GAME_XWIN;
        else if (o_win)
          game_state <= GAME_OWIN;
        else if (next_count == 4'd9)
          game_state <= GAME_DRAW;
      end
    end
  end

endmodule

// File: tb/tb_game_board_m.sv
// Bench for game_board_m: directed game sequences plus random moves,
// all checked against an array-based tic-tac-toe reference model.
module tb_game_board_m;

  logic        clk = 1'b0;
  logic        reset;
  logic        update_valid;
  logic [3:0]  update_loc;
  logic [1:0]  update_val;
  logic [17:0] board;
  logic [1:0]  turn;
  logic [3:0]  move_count;
  logic [1:0]  game_state;
  logic        err;
  logic [2:0]  err_code;

  int tests = 0;
  int fails = 0;

  int m_cell [9];
  int m_turn, m_cnt, m_gs, m_err, m_code;

  int lines [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  game_board_m dut (
    .clk          (clk),
    .reset        (reset),
    .update_valid (update_valid),
    .update_loc   (update_loc),
    .update_val   (update_val),
    .board        (board),
    .turn         (turn),
    .move_count   (move_count),
    .game_state   (game_state),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic has_line(input int p);
    for (int l = 0; l < 8; l++)
      if (m_cell[lines[l][0]] == p && m_cell[lines[l][1]] == p &&
          m_cell[lines[l][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input int v, input int loc, input int val,
                       input int rst);
    if (rst != 0) begin
      foreach (m_cell[i]) m_cell[i] = 0;
      m_turn = 1; m_cnt = 0; m_gs = 0; m_err = 0; m_code = 0;
      return;
    end
    m_err = 0;
    if (v == 0) return;
    if (m_gs != 0) m_code = 1;
    else if (loc > 8) m_code = 2;
    else if (val != 1 && val != 2) m_code = 3;
    else if (m_cell[loc] != 0) m_code = 4;
    else if (val != m_turn) m_code = 5;
    else m_code = 0;
    if (m_code != 0) begin
      m_err = 1;
      return;
    end
    m_cell[loc] = val;
    m_cnt++;
    m_turn = 3 - m_turn;
    if (has_line(val)) m_gs = val;
    else if (m_cnt == 9) m_gs = 3;
  endtask

  task automatic step(input int v, input int loc, input int val,
                      input int rst);
    logic [17:0] exp_b;
    reset        = rst[0];
    update_valid = v[0];
    update_loc   = loc[3:0];
    update_val   = val[1:0];
    @(posedge clk);
    model(v, loc, val, rst);
    @(negedge clk);
    exp_b = '0;
    for (int i = 0; i < 9; i++) exp_b[2*i +: 2] = m_cell[i][1:0];
    check("board", 32'(board), 32'(exp_b));
    check("turn", 32'(turn), 32'(m_turn));
    check("move_count", 32'(move_count), 32'(m_cnt));
    check("game_state", 32'(game_state), 32'(m_gs));
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
  endtask

  task automatic mv(input int loc, input int val);
    step(1, loc, val, 0);
  endtask

  task automatic rst_cycle();
    step(0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1; update_valid = 1'b0;
    update_loc = '0; update_val = '0;
    @(negedge clk);
    rst_cycle();
    check("reset_board", 32'(board), 32'd0);

    mv(0, 2);
    check("turn_err", 32'(err_code), 32'd5);

    rst_cycle();
    mv(0, 1); mv(4, 2); mv(0, 1);
    check("occupied", 32'(err_code), 32'd4);
    step(0, 0, 0, 0);
    check("err_pulse", 32'(err), 32'd0);

    rst_cycle();
    mv(8, 1); mv(9, 2); mv(1, 3);
    check("value_err", 32'(err_code), 32'd3);

    rst_cycle();
    mv(0, 1); mv(3, 2); mv(1, 1); mv(4, 2); mv(2, 1);
    check("xwin", 32'(game_state), 32'd1);
    mv(5, 2);
    check("over", 32'(err_code), 32'd1);

    rst_cycle();
    mv(0, 1); mv(1, 2); mv(2, 1); mv(4, 2); mv(3, 1);
    mv(5, 2); mv(7, 1); mv(6, 2); mv(8, 1);
    check("draw", 32'(game_state), 32'd3);

    rst_cycle();
    mv(0, 1); mv(1, 2); mv(2, 1); mv(4, 2); mv(3, 1);
    mv(5, 2); mv(7, 1); mv(8, 2); mv(6, 1);
    check("win9", 32'(game_state), 32'd1);

    rst_cycle();
    mv(4, 1); mv(0, 2);
    step(1, 8, 1, 1);
    check("rst_over_move", 32'(move_count), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      int v, loc, val, rst;
      rst = ($urandom_range(0, 99) < 2) ? 1 : 0;
      v   = ($urandom_range(0, 99) < 80) ? 1 : 0;
      loc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15))
                                        : int'($urandom_range(0, 8));
      val = ($urandom_range(0, 99) < 85) ? m_turn
                                         : int'($urandom_range(0, 3));
      if (m_gs != 0 && $urandom_range(0, 3) == 0) rst = 1;
      step(v, loc, val, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
